// File: rtl/system_worker1_cpu_ocm_arb.sv
// system_worker1_cpu_ocm_arb
//   Two-master front end for the worker1 CPU's single-port on-chip debug
//   memory. Port A (CPU data master) and port B (JTAG debug master) are
//   arbitrated round-robin. One access is issued to the OCM per cycle. Read
//   data returns two cycles after issue and is steered back to the issuing
//   port. No grants are issued while reset_req is high.
//
// Ports
//   clk, reset_n                  clock, asynchronous active-low reset
//   reset_req                     pending-reset hint, blocks new grants
//   a_* / b_*                     Avalon-MM slave ports (address, byteenable,
//                                 read, write, writedata, waitrequest,
//                                 readdata, readdatavalid)
//   ocm_address/byteenable/
//   chipselect/write/writedata    OCM request (combinational mux of the winner)
//   ocm_clken                     OCM clock enable (~reset_req)
//   ocm_readdata                  OCM q, valid one cycle after issue
module system_worker1_cpu_ocm_arb #(
    parameter int ADDR_W = 7,
    parameter int DATA_W = 32,
    parameter int BE_W   = 4
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              reset_req,

    input  logic [ADDR_W-1:0] a_address,
    input  logic [BE_W-1:0]   a_byteenable,
    input  logic              a_read,
    input  logic              a_write,
    input  logic [DATA_W-1:0] a_writedata,
    output logic              a_waitrequest,
    output logic [DATA_W-1:0] a_readdata,
    output logic              a_readdatavalid,

    input  logic [ADDR_W-1:0] b_address,
    input  logic [BE_W-1:0]   b_byteenable,
    input  logic              b_read,
    input  logic              b_write,
    input  logic [DATA_W-1:0] b_writedata,
    output logic              b_waitrequest,
    output logic [DATA_W-1:0] b_readdata,
    output logic              b_readdatavalid,

    output logic [ADDR_W-1:0] ocm_address,
    output logic [BE_W-1:0]   ocm_byteenable,
    output logic              ocm_chipselect,
    output logic              ocm_write,
    output logic [DATA_W-1:0] ocm_writedata,
    output logic              ocm_clken,
    input  logic [DATA_W-1:0] ocm_readdata
);

    localparam int STAGES = 2;

    logic              req_a, req_b;
    logic              grant_a, grant_b;
    logic              issue_rd;
    logic              contested;
    logic              last_b;          // 1: B won the last contested grant
    logic [STAGES:1]   vld_pipe;        // read in flight, per stage
    logic [STAGES:1]   port_pipe;       // issuing port per stage, 1 = B
    logic [DATA_W-1:0] rdata_q;         // shared return data register

    // Arbitration: a sole requester always wins; on contention the port
    // opposite the previous contested winner wins.
    always_comb begin
        req_a     = a_read | a_write;
        req_b     = b_read | b_write;
        contested = req_a & req_b & ~reset_req;
        grant_a   = ~reset_req & req_a & (~req_b | last_b);
        grant_b   = ~reset_req & req_b & ~grant_a;
    end

    assign a_waitrequest = req_a & ~grant_a;
    assign b_waitrequest = req_b & ~grant_b;

    // OCM drive. read+write together is treated as a write, so it never
    // enters the return pipeline.
    always_comb begin
        ocm_address    = grant_b ? b_address    : a_address;
        ocm_byteenable = grant_b ? b_byteenable : a_byteenable;
        ocm_writedata  = grant_b ? b_writedata  : a_writedata;
        ocm_chipselect = grant_a | grant_b;
        ocm_write      = (grant_a & a_write) | (grant_b & b_write);
        issue_rd       = ocm_chipselect & ~ocm_write;
    end

    assign ocm_clken = ~reset_req;

    // Return pipeline. reset_req deliberately does not stall or flush it:
    // the OCM holds its address while clken is low, so q stays valid.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            last_b    <= 1'b1;
            vld_pipe  <= '0;
            port_pipe <= '0;
            rdata_q   <= '0;
        end else begin
            if (contested)
                last_b <= grant_b;
            vld_pipe[1]  <= issue_rd;
            port_pipe[1] <= grant_b;
            vld_pipe[2]  <= vld_pipe[1];
            port_pipe[2] <= port_pipe[1];
            if (vld_pipe[1])
                rdata_q <= ocm_readdata;
        end
    end

    assign a_readdatavalid = vld_pipe[STAGES] & ~port_pipe[STAGES];
    assign b_readdatavalid = vld_pipe[STAGES] &  port_pipe[STAGES];
    assign a_readdata      = rdata_q;
    assign b_readdata      = rdata_q;

endmodule
